thresh_preset_applier: RTL and testbench

Consumer side of the threshold-preset selector. It watches the selected preset enum and its threshold/timer values, waits for the selection to settle, then pushes the threshold and timer into the accelerometer driver. It does this as two sequential register-write transactions on a req/ack handshake, and reports the preset that is actually applied. It sits between the preset selector and the ACL SPI command driver in the 20 MHz domain.

---
 rtl/thresh_preset_applier.sv | 149 ++++++++++++++
 tb/tb_thresh_preset_applier.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/thresh_preset_applier.sv
// rtl/thresh_preset_applier.sv - settles on a selected threshold preset and writes it to the ACL driver
`timescale 1ns/1ps
module thresh_preset_applier #(
  parameter int unsigned parm_settle_cycles = 20000,
  parameter int unsigned parm_ack_timeout   = 2000000
) (
  input  logic        i_clk_20mhz,
  input  logic        i_rstn_20mhz,
  input  logic [3:0]  i_value_enum,
  input  logic [15:0] i_value_thresh,
  input  logic [15:0] i_value_timer,
  input  logic        i_wr_ack,
  output logic        o_wr_req,
  output logic        o_wr_sel,
  output logic [15:0] o_wr_data,
  output logic [3:0]  o_applied_enum,
  output logic        o_apply_done,
  output logic        o_busy,
  output logic        o_wr_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_WR_THR,
    ST_GAP,
    ST_WR_TMR,
    ST_DONE
  } state_t;

  localparam logic [23:0] SETTLE_LAST = 24'(parm_settle_cycles - 1);
  localparam logic [23:0] ACK_LAST    = 24'(parm_ack_timeout - 1);

  state_t      state, state_nxt;
  logic [3:0]  s_enum_seen;
  logic [3:0]  s_hold_enum;
  logic [15:0] s_hold_tmr;
  logic [23:0] s_cnt;

  logic enum_chg, settle_end, ack_end;
  logic load_seen, cnt_clr, cnt_inc, capture, start_tmr, set_err, finish;

  assign enum_chg   = (i_value_enum != s_enum_seen);
  assign settle_end = (s_cnt == SETTLE_LAST);
  assign ack_end    = (s_cnt == ACK_LAST);

  always_comb begin
    state_nxt = state;
    load_seen = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    capture   = 1'b0;
    start_tmr = 1'b0;
    set_err   = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enum_chg) begin
          load_seen = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (enum_chg) begin
          load_seen = 1'b1;
          cnt_clr   = 1'b1;
        end else if (settle_end) begin
          capture   = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = ST_WR_THR;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_WR_THR: begin
        if (i_wr_ack) begin
          cnt_clr   = 1'b1;
          state_nxt = ST_GAP;
        end else if (ack_end) begin
          set_err   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_GAP: begin
        start_tmr = 1'b1;
        state_nxt = ST_WR_TMR;
      end
      ST_WR_TMR: begin
        if (i_wr_ack) begin
          cnt_clr   = 1'b1;
          finish    = 1'b1;
          state_nxt = ST_DONE;
        end else if (ack_end) begin
          set_err   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Reset lands in SETTLE with enum_seen=0 so the preset present at release is always applied once.
  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) state <= ST_SETTLE;
    else               state <= state_nxt;
  end

  // o_wr_data doubles as the held threshold; it is loaded with the capture and kept until the timer write.
  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) begin
      s_enum_seen    <= '0;
      s_hold_enum    <= '0;
      s_hold_tmr     <= '0;
      s_cnt          <= '0;
      o_wr_sel       <= 1'b0;
      o_wr_data      <= '0;
      o_applied_enum <= '0;
      o_wr_err       <= 1'b0;
    end else begin
      if (load_seen) s_enum_seen <= i_value_enum;
      if (cnt_clr)      s_cnt <= '0;
      else if (cnt_inc) s_cnt <= s_cnt + 24'd1;
      if (capture) begin
        s_hold_enum <= i_value_enum;
        s_hold_tmr  <= i_value_timer;
        o_wr_sel    <= 1'b0;
        o_wr_data   <= i_value_thresh;
      end
      if (start_tmr) begin
        o_wr_sel  <= 1'b1;
        o_wr_data <= s_hold_tmr;
      end
      if (finish) o_applied_enum <= s_hold_enum;
      if (set_err)     o_wr_err <= 1'b1;
      else if (finish) o_wr_err <= 1'b0;
    end
  end

  assign o_wr_req     = (state == ST_WR_THR) || (state == ST_WR_TMR);
  assign o_apply_done = (state == ST_DONE);
  assign o_busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_thresh_preset_applier.sv
// tb/tb_thresh_preset_applier.sv - scoreboard bench for thresh_preset_applier
`timescale 1ns/1ps
module tb_thresh_preset_applier;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  enum_v = 4'd0;
  logic [15:0] thr = 16'd0;
  logic [15:0] tmr = 16'd0;
  logic        resp_ack = 1'b0;
  logic        stray_ack = 1'b0;
  logic        ack;
  logic        req, sel, done, busy, err;
  logic [15:0] data;
  logic [3:0]  applied;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  bit withhold = 1'b0;

  logic [16:0] exp_wr[$];
  logic [3:0]  exp_enum[$];

  assign ack = resp_ack | stray_ack;

  thresh_preset_applier #(
    .parm_settle_cycles(4),
    .parm_ack_timeout(8)
  ) dut (
    .i_clk_20mhz(clk),
    .i_rstn_20mhz(rstn),
    .i_value_enum(enum_v),
    .i_value_thresh(thr),
    .i_value_timer(tmr),
    .i_wr_ack(ack),
    .o_wr_req(req),
    .o_wr_sel(sel),
    .o_wr_data(data),
    .o_applied_enum(applied),
    .o_apply_done(done),
    .o_busy(busy),
    .o_wr_err(err)
  );

  always #25 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic push_apply(input logic [3:0] e, input logic [15:0] t, input logic [15:0] m);
    exp_wr.push_back({1'b0, t});
    exp_wr.push_back({1'b1, m});
    exp_enum.push_back(e);
  endtask

  task automatic set_preset(input logic [3:0] e, input logic [15:0] t, input logic [15:0] m);
    enum_v = e;
    thr    = t;
    tmr    = m;
  endtask

  task automatic wait_done(input int target, input string tag);
    for (int i = 0; i < 400 && done_cnt < target; i++) step();
    check(tag, done_cnt, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, req, 1'b0);
    check({tag, "_sel"}, sel, 1'b0);
    check({tag, "_data"}, data, 16'h0000);
    check({tag, "_applied"}, applied, 4'd0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_busy"}, busy, 1'b1);
    check({tag, "_err"}, err, 1'b0);
  endtask

  // Driver model: ack three negedges after each req rise unless withheld.
  initial begin
    int   pend;
    logic rq;
    pend = 0;
    rq   = 1'b0;
    forever begin
      @(negedge clk);
      resp_ack = 1'b0;
      if (!rstn) pend = 0;
      else if (req && !rq && !withhold) pend = 3;
      else if (pend > 0) begin
        pend--;
        if (pend == 0) resp_ack = 1'b1;
      end
      rq = req;
    end
  end

  // Output monitor: each req rise pops a write, each apply_done pops an enum.
  initial begin
    logic        rq;
    logic [16:0] e;
    logic [3:0]  en;
    rq = 1'b0;
    forever begin
      @(negedge clk);
      if (req && !rq) begin
        check("write_expected", 32'(exp_wr.size() != 0), 1);
        if (exp_wr.size() != 0) begin
          e = exp_wr.pop_front();
          check("write_sel_data", {sel, data}, e);
        end
      end
      if (done) begin
        done_cnt++;
        check("done_expected", 32'(exp_enum.size() != 0), 1);
        if (exp_enum.size() != 0) begin
          en = exp_enum.pop_front();
          check("applied_enum", applied, en);
        end
      end
      rq = req;
    end
  end

  initial begin
    int lat;
    int hi;
    lat = 0;
    hi  = 0;
    set_preset(4'd0, 16'h0100, 16'h0020);
    repeat (3) step();
    check_reset_outputs("reset");

    push_apply(4'd0, 16'h0100, 16'h0020);
    rstn = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (req) begin
        lat = i;
        break;
      end
    end
    check("reset_to_req_edges", lat, 4);
    wait_done(1, "apply0_done");
    step();
    check("apply0_applied", applied, 4'd0);
    check("apply0_busy", busy, 1'b0);
    check("apply0_err", err, 1'b0);

    // Enum change restarts settle; only preset 2 gets written.
    step();
    set_preset(4'd1, 16'h1111, 16'h0011);
    step();
    step();
    set_preset(4'd2, 16'h2222, 16'h0022);
    push_apply(4'd2, 16'h2222, 16'h0022);
    wait_done(2, "apply2_done");
    step();
    check("apply2_applied", applied, 4'd2);
    check("apply2_busy", busy, 1'b0);

    // Enum change during the timer write completes the held apply, then re-applies.
    push_apply(4'd3, 16'h3333, 16'h0033);
    set_preset(4'd3, 16'h3333, 16'h0033);
    for (int i = 0; i < 100; i++) begin
      step();
      if (req && sel) break;
    end
    check("reached_wr_tmr", {req, sel}, 2'b11);
    set_preset(4'd4, 16'h4444, 16'h0044);
    push_apply(4'd4, 16'h4444, 16'h0044);
    wait_done(4, "apply4_done");
    step();
    check("apply4_applied", applied, 4'd4);
    check("apply4_busy", busy, 1'b0);

    // Ack timeout.
    withhold = 1'b1;
    exp_wr.push_back({1'b0, 16'h6666});
    set_preset(4'd6, 16'h6666, 16'h0066);
    for (int i = 0; i < 50; i++) begin
      step();
      if (req) break;
    end
    check("timeout_req_seen", req, 1'b1);
    hi = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (req) hi++;
      else break;
    end
    check("timeout_req_cycles", hi, 8);
    check("timeout_err", err, 1'b1);
    check("timeout_busy", busy, 1'b0);
    check("timeout_applied", applied, 4'd4);
    repeat (5) step();
    check("timeout_no_retry", busy, 1'b0);

    withhold = 1'b0;
    push_apply(4'd7, 16'h7777, 16'h0077);
    set_preset(4'd7, 16'h7777, 16'h0077);
    step();
    step();
    check("err_sticky", err, 1'b1);
    wait_done(5, "apply7_done");
    step();
    check("apply7_err_cleared", err, 1'b0);
    check("apply7_applied", applied, 4'd7);

    // Stray acks in IDLE and SETTLE.
    stray_ack = 1'b1;
    step();
    stray_ack = 1'b0;
    step();
    check("idle_stray_busy", busy, 1'b0);
    check("idle_stray_done", done_cnt, 5);
    push_apply(4'd8, 16'h8888, 16'h0088);
    set_preset(4'd8, 16'h8888, 16'h0088);
    step();
    step();
    stray_ack = 1'b1;
    step();
    stray_ack = 1'b0;
    check("settle_stray_req", req, 1'b0);
    check("settle_stray_busy", busy, 1'b1);
    wait_done(6, "apply8_done");
    step();
    check("apply8_applied", applied, 4'd8);

    // Reset in the middle of the threshold write.
    exp_wr.push_back({1'b0, 16'h9999});
    set_preset(4'd9, 16'h9999, 16'h0099);
    for (int i = 0; i < 50; i++) begin
      step();
      if (req) break;
    end
    check("pre_reset_req", req, 1'b1);
    #10;
    rstn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    push_apply(4'd9, 16'h9999, 16'h0099);
    step();
    step();
    rstn = 1'b1;
    wait_done(7, "apply9_done");
    step();
    check("apply9_applied", applied, 4'd9);
    check("apply9_busy", busy, 1'b0);
    check("apply9_err", err, 1'b0);

    check("writes_left", exp_wr.size(), 0);
    check("enums_left", exp_enum.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
